// File: rtl/dcache_pkg.sv
// dcache_pkg: shared widths and controller states for the data cache
package dcache_pkg;
  localparam int LINE_BITS = 128;
  localparam int WORD_BITS = 32;
  localparam int OFFSET_BITS = 4;
  typedef enum logic [2:0] {IDLE, WRITEBACK, WB_GAP, ALLOCATE, FILL} state_t;
endpackage

// File: rtl/dcache_line_store.sv
// dcache_line_store: valid/dirty/tag/data arrays, one combinational read port, one write port
//   rd_*  : combinational read of line rd_index_i
//   wr_*  : whole-line fill (valid=1, dirty=0, new tag) or single-word store (dirty=1)
module dcache_line_store
  import dcache_pkg::*;
#(
  parameter int LINES = 8,
  parameter int IW = $clog2(LINES),
  parameter int TW = 32 - OFFSET_BITS - IW
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [IW-1:0]        rd_index_i,
  output logic                 rd_valid_o,
  output logic                 rd_dirty_o,
  output logic [TW-1:0]        rd_tag_o,
  output logic [LINE_BITS-1:0] rd_line_o,
  input  logic                 wr_line_en_i,
  input  logic                 wr_word_en_i,
  input  logic [IW-1:0]        wr_index_i,
  input  logic [TW-1:0]        wr_tag_i,
  input  logic [LINE_BITS-1:0] wr_line_i,
  input  logic [1:0]           wr_sel_i,
  input  logic [WORD_BITS-1:0] wr_word_i
);
  logic [LINES-1:0] valid_q, dirty_q;
  logic [TW-1:0] tag_q [LINES];
  logic [LINE_BITS-1:0] data_q [LINES];
  assign rd_valid_o = valid_q[rd_index_i];
  assign rd_dirty_o = dirty_q[rd_index_i];
  assign rd_tag_o = tag_q[rd_index_i];
  assign rd_line_o = data_q[rd_index_i];
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_line_en_i) begin
      valid_q[wr_index_i] <= 1'b1;
      dirty_q[wr_index_i] <= 1'b0;
    end else if (wr_word_en_i)
      dirty_q[wr_index_i] <= 1'b1;
  // tag and data are only meaningful behind valid, so they carry no reset
  always_ff @(posedge clock)
    if (wr_line_en_i) begin
      data_q[wr_index_i] <= wr_line_i;
      tag_q[wr_index_i] <= wr_tag_i;
    end else if (wr_word_en_i)
      data_q[wr_index_i][wr_sel_i*WORD_BITS +: WORD_BITS] <= wr_word_i;
endmodule

// File: rtl/data_cache.sv
// data_cache: direct-mapped write-back, write-allocate data cache
//   cpu_*  : load/store request held until stall low; cpu_read_data valid on a load hit
//   mem_*  : block memory port, request levels with one-cycle completion pulses
module data_cache
  import dcache_pkg::*;
#(
  parameter int LINES = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 cpu_read,
  input  logic                 cpu_write,
  input  logic [31:0]          cpu_address,
  input  logic [WORD_BITS-1:0] cpu_write_data,
  output logic [WORD_BITS-1:0] cpu_read_data,
  output logic                 stall,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic [31:0]          mem_read_address,
  output logic [31:0]          mem_write_address,
  output logic [LINE_BITS-1:0] mem_write_data,
  input  logic [LINE_BITS-1:0] mem_read_data,
  input  logic                 mem_read_valid,
  input  logic                 mem_write_done
);
  localparam int IW = $clog2(LINES);
  localparam int TW = 32 - OFFSET_BITS - IW;
  state_t state_q, state_d;
  logic [31:OFFSET_BITS] addr_q, addr_d, blk;
  logic [LINE_BITS-1:0] fill_q, fill_d, rd_line;
  logic [IW-1:0] idx;
  logic [TW-1:0] tag, rd_tag;
  logic rd_valid, rd_dirty, hit, wr_line_en, wr_word_en, unused;
  // the live address is used while idle; the captured one for the rest of a miss
  assign blk = (state_q == IDLE) ? cpu_address[31:OFFSET_BITS] : addr_q;
  assign idx = blk[OFFSET_BITS+IW-1:OFFSET_BITS];
  assign tag = blk[31:OFFSET_BITS+IW];
  assign hit = rd_valid && rd_tag == tag;
  assign unused = ^cpu_address[1:0];
  assign mem_read_address = {addr_q, 4'b0};
  assign mem_write_address = {rd_tag, idx, 4'b0};
  assign mem_write_data = rd_line;
  dcache_line_store #(.LINES(LINES)) u_store (
    .clock(clock),
    .reset_n(reset_n),
    .rd_index_i(idx),
    .rd_valid_o(rd_valid),
    .rd_dirty_o(rd_dirty),
    .rd_tag_o(rd_tag),
    .rd_line_o(rd_line),
    .wr_line_en_i(wr_line_en),
    .wr_word_en_i(wr_word_en),
    .wr_index_i(idx),
    .wr_tag_i(tag),
    .wr_line_i(fill_q),
    .wr_sel_i(cpu_address[3:2]),
    .wr_word_i(cpu_write_data)
  );
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    fill_d = fill_q;
    stall = 1'b1;
    mem_read = 1'b0;
    mem_write = 1'b0;
    wr_line_en = 1'b0;
    wr_word_en = 1'b0;
    cpu_read_data = '0;
    case (state_q)
      IDLE: begin
        stall = (cpu_read || cpu_write) && !hit;
        // read and write together is a store
        wr_word_en = cpu_write && hit;
        cpu_read_data = (cpu_read && !cpu_write && hit) ? rd_line[cpu_address[3:2]*WORD_BITS +: WORD_BITS] : '0;
        if (stall) begin
          addr_d = cpu_address[31:OFFSET_BITS];
          state_d = (rd_valid && rd_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        mem_write = 1'b1;
        state_d = mem_write_done ? WB_GAP : WRITEBACK;
      end
      // one idle cycle so the memory sees a fresh request edge
      WB_GAP: state_d = ALLOCATE;
      ALLOCATE: begin
        mem_read = 1'b1;
        fill_d = mem_read_valid ? mem_read_data : fill_q;
        state_d = mem_read_valid ? FILL : ALLOCATE;
      end
      FILL: begin
        wr_line_en = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      addr_q <= '0;
      fill_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      fill_q <= fill_d;
    end
endmodule

// File: tb/tb_data_cache.sv
// tb_data_cache: randomized check of data_cache against a cache/memory reference model
module tb_data_cache;
  localparam int LINES = 8;
  logic clock = 0, reset_n = 0, cpu_read = 0, cpu_write = 0;
  logic [31:0] cpu_address = 0, cpu_write_data = 0, cpu_read_data;
  logic stall, mem_read, mem_write, mem_read_valid, mem_write_done;
  logic [31:0] mem_read_address, mem_write_address;
  logic [127:0] mem_write_data, mem_read_data;
  data_cache #(.LINES(LINES)) dut (
    .clock(clock), .reset_n(reset_n), .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_address(cpu_address), .cpu_write_data(cpu_write_data), .cpu_read_data(cpu_read_data),
    .stall(stall), .mem_read(mem_read), .mem_write(mem_write),
    .mem_read_address(mem_read_address), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
    .mem_read_valid(mem_read_valid), .mem_write_done(mem_write_done)
  );
  always #5 clock = ~clock;
  int n_chk, n_pass;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  function automatic logic [127:0] init_line(int unsigned b);
    logic [127:0] r;
    for (int k = 0; k < 4; k++) r[k*32 +: 32] = (b * 32'h9E3779B1 + k * 32'h01010101) ^ 32'h5A5A0000;
    return r;
  endfunction
  logic [127:0] mem [int unsigned];
  logic [127:0] ref_mem [int unsigned];
  function automatic logic [127:0] mem_get(int unsigned b);
    return mem.exists(b) ? mem[b] : init_line(b);
  endfunction
  function automatic logic [127:0] ref_get(int unsigned b);
    return ref_mem.exists(b) ? ref_mem[b] : init_line(b);
  endfunction
  int cyc, rd_cnt, wr_cnt, rd_lat, wr_lat, last_rd_lat, last_wr_lat, n_rd, n_wr;
  int rd_start, last_rd_start, last_done_cyc, both_cnt;
  logic [31:0] last_rd_addr, last_wr_addr;
  logic [127:0] last_wr_data;
  initial begin
    mem_read_valid = 0;
    mem_write_done = 0;
    mem_read_data = '0;
    forever begin
      @(negedge clock);
      cyc++;
      mem_read_valid = 0;
      mem_write_done = 0;
      if (mem_read && mem_write) both_cnt++;
      if (mem_read) begin
        if (rd_cnt == 0) begin
          rd_lat = $urandom_range(1, 4);
          rd_start = cyc;
        end
        rd_cnt++;
        if (rd_cnt == rd_lat) begin
          mem_read_data = mem_get(mem_read_address >> 4);
          mem_read_valid = 1;
          rd_cnt = 0;
          last_rd_lat = rd_lat;
          last_rd_addr = mem_read_address;
          last_rd_start = rd_start;
          n_rd++;
        end
      end else rd_cnt = 0;
      if (mem_write) begin
        if (wr_cnt == 0) wr_lat = $urandom_range(1, 4);
        wr_cnt++;
        if (wr_cnt == wr_lat) begin
          mem[mem_write_address >> 4] = mem_write_data;
          mem_write_done = 1;
          wr_cnt = 0;
          last_wr_lat = wr_lat;
          last_wr_addr = mem_write_address;
          last_wr_data = mem_write_data;
          last_done_cyc = cyc;
          n_wr++;
        end
      end else wr_cnt = 0;
    end
  end
  bit rv [LINES];
  bit rdy [LINES];
  int unsigned rblk [LINES];
  logic [127:0] rline [LINES];
  task automatic ref_reset();
    for (int i = 0; i < LINES; i++) begin
      rv[i] = 0;
      rdy[i] = 0;
    end
  endtask
  task automatic do_op(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wd);
    int unsigned b = addr >> 4;
    int idx = b % LINES;
    int w = (addr >> 2) % 4;
    int n0_rd = n_rd;
    int n0_wr = n_wr;
    int n = 0;
    int exp_n;
    bit hit, wb;
    int unsigned wb_blk = 0;
    logic [127:0] wb_data = '0;
    logic [31:0] exp_rd, got;
    hit = rv[idx] && rblk[idx] == b;
    wb = !hit && rv[idx] && rdy[idx];
    if (!hit) begin
      if (wb) begin
        wb_blk = rblk[idx];
        wb_data = rline[idx];
        ref_mem[wb_blk] = wb_data;
      end
      rline[idx] = ref_get(b);
      rv[idx] = 1;
      rdy[idx] = 0;
      rblk[idx] = b;
    end
    if (wr) begin
      rline[idx][w*32 +: 32] = wd;
      rdy[idx] = 1;
    end
    exp_rd = rline[idx][w*32 +: 32];
    @(negedge clock);
    cpu_read = rd;
    cpu_write = wr;
    cpu_address = addr;
    cpu_write_data = wd;
    #1;
    while (stall && n < 200) begin
      @(negedge clock);
      #1;
      n++;
    end
    got = cpu_read_data;
    @(posedge clock);
    #1;
    cpu_read = 0;
    cpu_write = 0;
    exp_n = hit ? 0 : last_rd_lat + 2 + (wb ? last_wr_lat + 1 : 0);
    chk("stall_cycles", n, exp_n);
    chk("rd_xfers", n_rd - n0_rd, hit ? 0 : 1);
    chk("wr_xfers", n_wr - n0_wr, wb ? 1 : 0);
    if (!hit) chk("rd_addr", last_rd_addr, b << 4);
    if (wb) begin
      chk("wb_addr", last_wr_addr, wb_blk << 4);
      chk("wb_data", last_wr_data, wb_data);
      chk("wb_gap", last_rd_start - last_done_cyc, 2);
    end
    if (rd && !wr) chk("load_data", got, exp_rd);
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
  initial begin
    int n;
    ref_reset();
    repeat (3) @(negedge clock);
    chk("rst_stall", stall, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    chk("rst_rdata", cpu_read_data, 0);
    reset_n = 1;
    do_op(1, 0, 32'h40, 0);
    do_op(0, 1, 32'h44, 32'hDEADBEEF);
    do_op(1, 0, 32'h44, 0);
    do_op(1, 0, 32'hC4, 0);
    chk("wb_word1", last_wr_data[63:32], 32'hDEADBEEF);
    chk("alloc_c0", last_rd_addr, 32'hC0);
    do_op(1, 0, 32'h44, 0);
    @(negedge clock);
    cpu_read = 1;
    cpu_address = 32'h144;
    n = 0;
    #1;
    while (!mem_read && n < 20) begin
      @(negedge clock);
      #1;
      n++;
    end
    chk("alloc_seen", mem_read, 1);
    reset_n = 0;
    #1;
    chk("rst_alloc_mem_read", mem_read, 0);
    chk("rst_alloc_mem_write", mem_write, 0);
    cpu_read = 0;
    #1;
    chk("rst_alloc_stall", stall, 0);
    chk("rst_alloc_rdata", cpu_read_data, 0);
    ref_reset();
    @(negedge clock);
    reset_n = 1;
    do_op(1, 0, 32'h144, 0);
    do_op(1, 0, 32'h44, 0);
    do_op(1, 1, 32'h80, 32'h12345678);
    do_op(1, 0, 32'h80, 0);
    @(negedge clock);
    #2;
    mem_read_valid = 1;
    mem_write_done = 1;
    mem_read_data = '1;
    @(negedge clock);
    #1;
    chk("stray_stall", stall, 0);
    chk("stray_mem_read", mem_read, 0);
    do_op(1, 0, 32'h84, 0);
    repeat (300) begin
      int op = $urandom_range(0, 9);
      logic [31:0] a = ($urandom_range(0, 31) << 4) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      do_op(op < 5 || op == 9, op >= 5, a, $urandom);
    end
    chk("rd_wr_exclusive", both_cnt, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/data_cache.md
DATA_CACHE -- requirements
Module: data_cache

Interface
REQ-001 Parameter: LINES, 8, number of direct-mapped lines (power of two, 2..64).
REQ-002 Port: clock  in  1  single clock, all state updates on rising edge.
REQ-003 Port: reset_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: cpu_read  in  1  load request, held until stall low.
REQ-005 Port: cpu_write  in  1  store request, held until stall low.
REQ-006 Port: cpu_address  in  32  byte address; bits [1:0] ignored.
REQ-007 Port: cpu_write_data  in  32  store word.
REQ-008 Port: cpu_read_data  out  32  load word, valid when cpu_read high and stall low.
REQ-009 Port: stall  out  1  high while the request cannot complete this cycle.
REQ-010 Port: mem_read / mem_write  out  1 each  block-memory request levels.
REQ-011 Port: mem_read_address / mem_write_address  out  32 each  16-byte-aligned block addresses.
REQ-012 Port: mem_write_data  out  128  victim line; word 0 in bits [31:0].
REQ-013 Port: mem_read_data  in  128  fill line; word 0 in bits [31:0].
REQ-014 Port: mem_read_valid / mem_write_done  in  1 each  one-cycle completion pulses.

Function
REQ-015 Address split SHALL be: offset [3:2] word select; index [3+log2(LINES):4]; tag = remaining upper bits.
REQ-016 Each line SHALL hold valid, dirty, tag, 128-bit data; write-back, write-allocate policy.
REQ-017 States SHALL be IDLE, WRITEBACK, WB_GAP, ALLOCATE, FILL.
REQ-018 IDLE hit (valid and tag match): stall low combinationally in the same cycle; load returns word combinationally; store updates word and sets dirty at the next edge.
REQ-019 IDLE miss: stall high; go to WRITEBACK if victim valid and dirty, else ALLOCATE.
REQ-020 WRITEBACK: mem_write high, mem_write_address = {victim tag, index, 4'b0}, mem_write_data = victim line, all held stable; on mem_write_done go to WB_GAP.
REQ-021 WB_GAP: mem_write and mem_read low for exactly one cycle, then ALLOCATE (guarantees a fresh rising edge for the memory).
REQ-022 ALLOCATE: mem_read high, mem_read_address = {cpu_address[31:4], 4'b0}; on mem_read_valid capture mem_read_data and go to FILL.
REQ-023 FILL: write line with valid=1, dirty=0, new tag; mem_read low; next state IDLE, where the request re-evaluates as a hit.
REQ-024 Miss latency SHALL be: clean miss = memory read latency + 2 cycles; dirty miss additionally memory write latency + 1 cycle.
REQ-025 mem_read and mem_write SHALL never be high in the same cycle; each SHALL fall in the cycle after its completion pulse.
REQ-026 cpu_read and cpu_write both high SHALL be treated as a store.
REQ-027 No request in IDLE: stall low, no state change; completion pulses arriving outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-028 Request inputs changing while stall high is illegal; address and data are captured into request registers on the miss cycle and only those are used until FILL.

Reset
REQ-029 reset_n low SHALL immediately force state IDLE, all valid and dirty bits 0, mem_read=0, mem_write=0, stall=0 when no request, cpu_read_data=0.
REQ-030 Reset mid-WRITEBACK or mid-ALLOCATE SHALL abandon the transfer; the dirty victim is lost by design; data and tag arrays need no reset.

Structure
REQ-031 Package dcache_pkg SHALL hold the state enum, LINE_BITS=128, WORD_BITS=32, OFFSET_BITS=4.
REQ-032 Sub-module dcache_line_store SHALL hold the valid/dirty/tag/data arrays with one combinational read port and one write port (word or whole-line write).

Verification
REQ-033 Cold load 0x0000_0040 after reset -> stall high, ALLOCATE with mem_read_address 0x40, after fill cpu_read_data = word 0 of returned line, stall low.
REQ-034 Store 0xDEADBEEF to 0x44 then load 0x44 -> hit, no memory traffic, load returns 0xDEADBEEF.
REQ-035 With LINES=8, dirty line at 0x44, load 0xC4 -> WRITEBACK address 0x40 with word 1 = 0xDEADBEEF, one WB_GAP cycle, then ALLOCATE 0xC0.
REQ-036 Reload 0x44 after eviction -> miss, refill returns 0xDEADBEEF from memory.
REQ-037 Assert reset_n low during ALLOCATE -> mem_read low immediately; next load to the same address misses.
REQ-038 cpu_read and cpu_write both high at 0x80 -> performs store; mem_read and mem_write never simultaneously high (assertion over all tests).
